vga_fb_write_scheduler: RTL

- Sequences the single write port (A-port) of the 1-bit VGA frame buffer between two requesters:
  - the bus-side pixel writer, buffered through a small FIFO;
  - a hardware screen-clear/fill engine that sweeps the whole 160x120 raster.
- Guarantees write ordering across a clear: pixels issued before a clear request land before the sweep; pixels issued after land after it.
- Sits between the bus decode logic and the frame buffer.

---
 rtl/vga_fb_pkg.sv | 26 ++
 rtl/vga_fb_write_scheduler_fifo.sv | 70 +++++++
 rtl/vga_fb_write_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants, scheduler state type and address helper for the
// frame buffer write path.
package vga_fb_pkg;

  localparam int unsigned FB_ADDR_W = 15;
  localparam int unsigned FB_X_W    = 8;
  localparam int unsigned FB_Y_W    = 7;

  localparam int unsigned DEF_X_MAX = 159;
  localparam int unsigned DEF_Y_MAX = 119;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    CLEAR
  } sched_state_e;

  // Frame buffer addresses are {Y, X}.
  function automatic logic [FB_ADDR_W-1:0] fb_pack_addr(
    input logic [FB_Y_W-1:0] y,
    input logic [FB_X_W-1:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_fb_write_scheduler_fifo.sv
// Small synchronous FIFO holding bus-side pixel writes as {data, addr}.
module fb_pixel_fifo #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [15:0]                   wdata,
  input  logic                          pop,
  output logic [15:0]                   rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even if it pops in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Register FIFO state; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vga_fb_write_scheduler.sv
// Arbitrates the frame buffer A-port between queued bus pixel writes and
// the full-screen clear engine, keeping write order across a clear.
module vga_fb_write_scheduler
  import vga_fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned X_MAX      = DEF_X_MAX,
  parameter int unsigned Y_MAX      = DEF_Y_MAX
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIX_VALID,
  input  logic [14:0] PIX_ADDR,
  input  logic        PIX_DATA,
  output logic        PIX_READY,
  input  logic        CLR_START,
  input  logic        CLR_VALUE,
  output logic        CLR_BUSY,
  output logic        CLR_DONE,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FB_X_W-1:0] X_LAST = FB_X_W'(X_MAX);
  localparam logic [FB_Y_W-1:0] Y_LAST = FB_Y_W'(Y_MAX);

  sched_state_e           state_q, state_d;
  logic [CW-1:0]          flush_cnt_q, flush_cnt_d;
  logic [FB_X_W-1:0]      x_q, x_d;
  logic [FB_Y_W-1:0]      y_q, y_d;
  logic                   clr_val_q, clr_val_d;
  logic                   sweep_end_q, sweep_end_d;
  logic                   fb_we_q, fb_we_d;
  logic [FB_ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic                   fb_data_q, fb_data_d;
  logic                   clr_busy_q, clr_busy_d;
  logic                   clr_done_q, clr_done_d;

  logic                   fifo_pop;
  logic [15:0]            fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;

  fb_pixel_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (PIX_VALID),
    .wdata ({PIX_DATA, PIX_ADDR}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign PIX_READY = !fifo_full;
  assign CLR_BUSY  = clr_busy_q;
  assign CLR_DONE  = clr_done_q;
  assign FB_ADDR   = fb_addr_q;
  assign FB_DATA   = fb_data_q;
  assign FB_WE     = fb_we_q;

  // Scheduling decision: drain queue, flush pre-clear entries, or sweep.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    clr_val_d   = clr_val_q;
    sweep_end_d = sweep_end_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    clr_busy_d  = clr_busy_q;
    clr_done_d  = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CLR_START) begin
          // No pop in the accepting cycle, so the snapshot is exactly the
          // set of pre-clear entries.
          clr_val_d   = CLR_VALUE;
          flush_cnt_d = fifo_count;
          clr_busy_d  = 1'b1;
          x_d         = '0;
          y_d         = '0;
          sweep_end_d = 1'b0;
          state_d     = (fifo_count != '0) ? FLUSH : CLEAR;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          fb_we_d   = 1'b1;
          fb_addr_d = fifo_rdata[14:0];
          fb_data_d = fifo_rdata[15];
        end
      end
      FLUSH: begin
        fifo_pop    = 1'b1;
        fb_we_d     = 1'b1;
        fb_addr_d   = fifo_rdata[14:0];
        fb_data_d   = fifo_rdata[15];
        flush_cnt_d = flush_cnt_q - CW'(1);
        if (flush_cnt_q == CW'(1)) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (sweep_end_q) begin
          // Extra cycle lets the last sweep write land before DONE/IDLE.
          state_d     = IDLE;
          clr_busy_d  = 1'b0;
          clr_done_d  = 1'b1;
          sweep_end_d = 1'b0;
        end else begin
          fb_we_d   = 1'b1;
          fb_addr_d = fb_pack_addr(y_q, x_q);
          fb_data_d = clr_val_q;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              sweep_end_d = 1'b1;
            end else begin
              y_d = y_q + FB_Y_W'(1);
            end
          end else begin
            x_d = x_q + FB_X_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state and registered frame buffer outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      clr_val_q   <= 1'b0;
      sweep_end_q <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      clr_val_q   <= clr_val_d;
      sweep_end_q <= sweep_end_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
    end
  end

endmodule
